// File: rtl/pkt_merge_pkg.sv
// Shared definitions for the packet merge arbiter: one-hot FSM encodings and
// the ctrl-word framing predicates used by packet-framing blocks.
package pkt_merge_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE = 3'b001;
  localparam state_t HDR  = 3'b010;
  localparam state_t BODY = 3'b100;

  // Widest ctrl bus the predicates accept; narrower buses are zero-extended.
  localparam int CTRL_MAX = 64;

  // A nonzero ctrl word leads the packet until the first body word is seen.
  function automatic logic is_hdr(input logic [CTRL_MAX-1:0] ctrl, input logic in_body);
    return (ctrl != '0) && !in_body;
  endfunction

  // After body words have started, the next nonzero ctrl word closes the packet.
  function automatic logic is_eop(input logic [CTRL_MAX-1:0] ctrl, input logic in_body);
    return (ctrl != '0) && in_body;
  endfunction

  function automatic logic [1:0] src_onehot(input logic src);
    return src ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small fall-through FIFO: head word visible on dout_o the cycle after it is written.
// nearly_full_o asserts with one free slot left so writers have a cycle of slack.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din_i,
  input  logic             wr_en_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             nearly_full_o,
  output logic             empty_o
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0]   FULL_LEVEL = (MAX_DEPTH_BITS+1)'(DEPTH);
  localparam logic [MAX_DEPTH_BITS:0]   NF_LEVEL   = (MAX_DEPTH_BITS+1)'(DEPTH - 1);
  localparam logic [MAX_DEPTH_BITS:0]   CNT_ONE    = 1;
  localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE    = 1;

  logic [WIDTH-1:0]          mem_q [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [MAX_DEPTH_BITS:0]   count_q, count_d;
  logic                      do_wr, do_rd;

  assign do_wr = wr_en_i && (count_q != FULL_LEVEL);
  assign do_rd = rd_en_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (do_wr && !do_rd) count_d = count_q + CNT_ONE;
    else if (!do_wr && do_rd) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o        = mem_q[rd_ptr_q];
  assign empty_o       = (count_q == '0);
  assign nearly_full_o = (count_q >= NF_LEVEL);

endmodule

// File: rtl/pkt_merge_arb.sv
// Round-robin packet-granular merge of the pass-through and probe streams onto one
// output; words forward combinationally from the owner FIFO head, gated by out_rdy.
module pkt_merge_arb
  import pkt_merge_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int FIFO_DEPTH_BITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in0_data,
  input  logic [CTRL_WIDTH-1:0] in0_ctrl,
  input  logic                  in0_wr,
  output logic                  in0_rdy,
  input  logic [DATA_WIDTH-1:0] in1_data,
  input  logic [CTRL_WIDTH-1:0] in1_ctrl,
  input  logic                  in1_wr,
  output logic                  in1_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic [1:0]            pkt_done,
  output logic [1:0]            cur_src
);

  localparam int W = CTRL_WIDTH + DATA_WIDTH;

  logic [W-1:0]          head0, head1, head;
  logic                  empty0, empty1, nf0, nf1, rd0, rd1;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  sel, sel_ne, in_body, eop;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q, last_d;

  fallthrough_small_fifo #(.WIDTH(W), .MAX_DEPTH_BITS(FIFO_DEPTH_BITS)) u_fifo0 (
    .clk           (clk),
    .reset         (reset),
    .din_i         ({in0_ctrl, in0_data}),
    .wr_en_i       (in0_wr),
    .rd_en_i       (rd0),
    .dout_o        (head0),
    .nearly_full_o (nf0),
    .empty_o       (empty0)
  );

  fallthrough_small_fifo #(.WIDTH(W), .MAX_DEPTH_BITS(FIFO_DEPTH_BITS)) u_fifo1 (
    .clk           (clk),
    .reset         (reset),
    .din_i         ({in1_ctrl, in1_data}),
    .wr_en_i       (in1_wr),
    .rd_en_i       (rd1),
    .dout_o        (head1),
    .nearly_full_o (nf1),
    .empty_o       (empty1)
  );

  assign in0_rdy = !nf0;
  assign in1_rdy = !nf1;

  // In IDLE the arbitration winner is selected so its first word goes out this cycle.
  always_comb begin
    if (state_q == IDLE) begin
      if (!empty0 && !empty1) sel = ~last_q;
      else                    sel = empty0;
    end else begin
      sel = owner_q;
    end
    sel_ne = sel ? !empty1 : !empty0;
    head   = sel ? head1 : head0;
    {head_ctrl, head_data} = head;
  end

  assign out_wr   = sel_ne && out_rdy;
  assign rd0      = out_wr && !sel;
  assign rd1      = out_wr && sel;
  assign out_data = out_wr ? head_data : '0;
  assign out_ctrl = out_wr ? head_ctrl : '0;

  assign in_body  = (state_q == BODY);
  assign eop      = out_wr && is_eop(CTRL_MAX'(head_ctrl), in_body);
  assign pkt_done = eop ? src_onehot(owner_q) : 2'b00;
  assign cur_src  = (state_q == IDLE) ? 2'b00 : src_onehot(owner_q);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    if (out_wr) begin
      case (state_q)
        IDLE: begin
          owner_d = sel;
          state_d = is_hdr(CTRL_MAX'(head_ctrl), 1'b0) ? HDR : BODY;
        end
        HDR: begin
          if (!is_hdr(CTRL_MAX'(head_ctrl), 1'b0)) state_d = BODY;
        end
        BODY: begin
          if (eop) begin
            last_d  = owner_q;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // last resets to input 1 so input 0 takes the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: doc/pkt_merge_arb.md
# pkt_merge_arb

Packet-granular two-input arbiter that merges the pass-through packet stream and the locally generated probe stream onto one user-datapath output. It sits between the upstream pipeline/probe generator pair and the output queues. Whole packets, module headers included, are forwarded without interleaving. Inputs are served round-robin at packet boundaries.

## Interface
Parameters:
- DATA_WIDTH, 64, datapath word width
- CTRL_WIDTH, DATA_WIDTH/8, ctrl bus width
- FIFO_DEPTH_BITS, 2, log2 depth of each input FIFO

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in0_data / in0_ctrl  in  DATA_WIDTH / CTRL_WIDTH  input 0 (pass-through) word
- in0_wr  in  1  input 0 write strobe
- in0_rdy  out  1  input 0 may write; equals !nearly_full of FIFO 0
- in1_data / in1_ctrl / in1_wr / in1_rdy  same as input 0, for input 1 (generator)
- out_data / out_ctrl  out  DATA_WIDTH / CTRL_WIDTH  merged word
- out_wr  out  1  output word valid
- out_rdy  in  1  downstream can accept a word this cycle
- pkt_done  out  2  one-cycle pulse per input when its EOP word is forwarded
- cur_src  out  2  one-hot owner of the output; 0 when idle

## Operation
- Each input is buffered in its own fall-through FIFO. Writes with `inN_wr` while FIFO N is full are a protocol violation and are not handled.
- Packet framing:
  - Header words have ctrl != 0 and lead the packet.
  - Body words have ctrl == 0.
  - The first word with ctrl != 0 that follows at least one body word is EOP.
- FSM, held in `state`:
  - IDLE
    - Candidate = nonempty FIFOs.
    - If both FIFOs are nonempty, the input != `last` wins.
    - If exactly one is nonempty, it wins.
    - If a winner exists and `out_rdy` is high, its head word is forwarded this cycle. Then: `owner <= winner`; go to HDR if that word had ctrl != 0, otherwise BODY.
  - HDR: forward owner words while FIFO nonempty and `out_rdy`. The first ctrl == 0 word moves to BODY.
  - BODY: forward owner words while FIFO nonempty and `out_rdy`. A ctrl != 0 word is EOP. On EOP: pulse `pkt_done[owner]`, `last <= owner`, go to IDLE.
- Forwarding is combinational from the FIFO head: `out_wr = rd_en = owner nonempty && out_rdy`, and `out_data`/`out_ctrl` = owner head. When `out_wr` = 0, `out_data`/`out_ctrl` drive 0.
- The non-owner FIFO keeps accepting writes while the output is locked. It is never read mid-packet.
- `cur_src` is the one-hot owner in HDR/BODY and 0 in IDLE.

## Timing
- Reset values:
  - state = IDLE, `last` = 1 (input 0 wins first tie)
  - out_wr = 0, out_data = out_ctrl = 0
  - pkt_done = 0, cur_src = 0
  - FIFOs empty, so in0_rdy = in1_rdy = 1 the cycle after reset deasserts
- Latency:
  - Input write at cycle t: the word is visible at the FIFO head at t+1 and forwarded at t+1 at the earliest.
  - No dead cycle between back-to-back packets from the same or different inputs. The IDLE decision and the first-word forward happen in the same cycle.
- `out_rdy` low: no read, state and owner hold, outputs 0.
- Owner FIFO empty mid-packet: hold the lock and emit a bubble. Never switch input.
- Reset mid-packet: FSM returns to IDLE and FIFOs flush. The partial packet is dropped and downstream sees a truncated stream. This is acceptable only at system reset.
- `pkt_done` is asserted in the same cycle the EOP word is on `out_data` with `out_wr` = 1.

## Structure
- Package `pkt_merge_pkg` holds:
  - state localparams IDLE = 1, HDR = 2, BODY = 4 (one-hot)
  - the `is_eop`/`is_hdr` ctrl predicates, shared with other packet-framing blocks
- Sub-modules: two instances of `fallthrough_small_fifo`, width CTRL_WIDTH+DATA_WIDTH, MAX_DEPTH_BITS = FIFO_DEPTH_BITS. No new sub-module.
- The FSM, owner/last flops and output mux live in the top module.

## Test plan
- Single packet on input 0: 1 header (ctrl=0xFF), 3 body words, EOP ctrl=0x01, out_rdy=1. Required: 5 consecutive out_wr cycles, words identical, pkt_done=01 on the 5th, cur_src back to 0 next cycle.
- Simultaneous packets on both inputs after reset. Required: input 0 packet fully first, then input 1 with no gap; pkt_done 01 then 10; no interleaved words.
- Continuous packets on both inputs (8 each). Required: strict alternation 0,1,0,1,…; 8 pkt_done pulses per input.
- Input 1 word written while input 0 owns the output mid-body. Required: no input 1 word appears until the cycle after input 0 EOP.
- out_rdy toggling 1/0 every cycle, plus a 3-cycle owner-FIFO underrun mid-body. Required: out_wr only when out_rdy=1 and data present; owner unchanged throughout; word order preserved.
- Reset asserted in BODY. Required: next cycle out_wr=0, cur_src=0, both inN_rdy=1; a new packet afterwards forwards cleanly from input 0.
